uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_datapath.sv | 68 ++++++
 rtl/uart_tx.sv | 88 ++++++++
 tb/tb_uart_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding (used by both TX and RX
// controllers) and the default link constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_WORD_SIZE    = 8;

endpackage

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: word shift register, data-bit counter and baud counter.
// The controller decides when to load and shift; this block only reports timing.
module uart_tx_datapath
    import uart_pkg::*;
#(
    parameter int WORD_SIZE          = UART_WORD_SIZE,
    parameter int WORD_SIZE_WIDTH    = 4,
    parameter int CLKS_PER_BIT       = UART_CLKS_PER_BIT,
    parameter int CLKS_PER_BIT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 load,
    input  logic                 active,
    input  logic                 shift,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic                 data_bit,
    output logic                 next_bit,
    output logic                 Baud_Tick,
    output logic                 baud_last_next,
    output logic                 Bit_Count_Reached
);

    localparam logic [CLKS_PER_BIT_WIDTH-1:0] BAUD_LAST = CLKS_PER_BIT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [WORD_SIZE_WIDTH-1:0]    BIT_ONE   = WORD_SIZE_WIDTH'(1);
    localparam logic [WORD_SIZE_WIDTH-1:0]    BIT_FULL  = WORD_SIZE_WIDTH'(WORD_SIZE);

    logic [WORD_SIZE-1:0]          shift_reg;
    logic [WORD_SIZE_WIDTH-1:0]    bit_cnt;
    logic [CLKS_PER_BIT_WIDTH-1:0] baud_cnt;
    logic [CLKS_PER_BIT_WIDTH-1:0] baud_cnt_nxt;

    assign Baud_Tick = (baud_cnt == BAUD_LAST);

    // Counter sits at 0 while idle so the first start-bit cycle is count 0.
    always_comb begin
        baud_cnt_nxt = baud_cnt + 1'b1;
        if (load || !active || Baud_Tick)
            baud_cnt_nxt = '0;
    end

    // Lets the controller register TX_Done so it lands on the last stop cycle.
    assign baud_last_next    = (baud_cnt_nxt == BAUD_LAST);
    // The bit finishing at this boundary brings the count to WORD_SIZE.
    assign Bit_Count_Reached = ((bit_cnt + BIT_ONE) == BIT_FULL);

    assign data_bit = shift_reg[0];
    assign next_bit = shift_reg[1];

    always_ff @(posedge clk) begin
        if (reset_b) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
        end else begin
            baud_cnt <= baud_cnt_nxt;
            if (load) begin
                shift_reg <= data_in;
                bit_cnt   <= '0;
            end else if (shift) begin
                // Fill with 1s so a drained register can never pull the line low.
                shift_reg <= {1'b1, shift_reg[WORD_SIZE-1:1]};
                bit_cnt   <= bit_cnt + BIT_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter controller: valid/ready intake, frame FSM and registered
// line/status outputs on top of uart_tx_datapath.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WORD_SIZE          = UART_WORD_SIZE,
    parameter int WORD_SIZE_WIDTH    = 4,
    parameter int CLKS_PER_BIT       = UART_CLKS_PER_BIT,
    parameter int CLKS_PER_BIT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic [WORD_SIZE-1:0] TX_Data_in,
    input  logic                 TX_Data_Valid,
    output logic                 TX_Ready,
    output logic                 TX_Data_out,
    output logic                 TX_Busy,
    output logic                 TX_Done
);

    uart_state_t state, state_nxt;
    logic load, active, shift;
    logic data_bit, next_bit, baud_tick, baud_last_next, bit_count_reached;
    logic line_nxt, ready_nxt, busy_nxt, done_nxt;

    // TX_Ready is only ever high in IDLE, so it doubles as the state qualifier.
    assign load   = TX_Data_Valid && TX_Ready;
    assign active = (state != IDLE);
    assign shift  = (state == DATA) && baud_tick;

    uart_tx_datapath #(
        .WORD_SIZE         (WORD_SIZE),
        .WORD_SIZE_WIDTH   (WORD_SIZE_WIDTH),
        .CLKS_PER_BIT      (CLKS_PER_BIT),
        .CLKS_PER_BIT_WIDTH(CLKS_PER_BIT_WIDTH)
    ) u_datapath (
        .clk              (clk),
        .reset_b          (reset_b),
        .load             (load),
        .active           (active),
        .shift            (shift),
        .data_in          (TX_Data_in),
        .data_bit         (data_bit),
        .next_bit         (next_bit),
        .Baud_Tick        (baud_tick),
        .baud_last_next   (baud_last_next),
        .Bit_Count_Reached(bit_count_reached)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load)                           state_nxt = START;
            START:   if (baud_tick)                      state_nxt = DATA;
            DATA:    if (baud_tick && bit_count_reached) state_nxt = STOP;
            STOP:    if (baud_tick)                      state_nxt = IDLE;
            default:                                     state_nxt = IDLE;
        endcase

        // Outputs are computed for the coming cycle and registered below.
        line_nxt = 1'b1;
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shift ? next_bit : data_bit;
            default: line_nxt = 1'b1;
        endcase
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = !ready_nxt;
        done_nxt  = (state_nxt == STOP) && baud_last_next;
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state       <= IDLE;
            TX_Data_out <= 1'b1;
            TX_Ready    <= 1'b1;
            TX_Busy     <= 1'b0;
            TX_Done     <= 1'b0;
        end else begin
            state       <= state_nxt;
            TX_Data_out <= line_nxt;
            TX_Ready    <= ready_nxt;
            TX_Busy     <= busy_nxt;
            TX_Done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances at CLKS_PER_BIT = 4, 1 and 16,
// driven and sampled on the falling clock edge.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] vld;
    logic [7:0] din [3];
    wire  [2:0] line, rdy, bsy, dn;

    int checks   = 0;
    int failures = 0;

    uart_tx #(.CLKS_PER_BIT(4)) u4 (
        .clk(clk), .reset_b(rst[0]), .TX_Data_in(din[0]), .TX_Data_Valid(vld[0]),
        .TX_Ready(rdy[0]), .TX_Data_out(line[0]), .TX_Busy(bsy[0]), .TX_Done(dn[0]));
    uart_tx #(.CLKS_PER_BIT(1)) u1 (
        .clk(clk), .reset_b(rst[1]), .TX_Data_in(din[1]), .TX_Data_Valid(vld[1]),
        .TX_Ready(rdy[1]), .TX_Data_out(line[1]), .TX_Busy(bsy[1]), .TX_Done(dn[1]));
    uart_tx #(.CLKS_PER_BIT(16)) u16 (
        .clk(clk), .reset_b(rst[2]), .TX_Data_in(din[2]), .TX_Data_Valid(vld[2]),
        .TX_Ready(rdy[2]), .TX_Data_out(line[2]), .TX_Busy(bsy[2]), .TX_Done(dn[2]));

    function automatic int cpb(int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Bit b of a frame: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic exp_bit(logic [7:0] w, int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return w[b-1];
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of the first start-bit cycle; returns one
    // falling edge after the last stop-bit cycle.
    task automatic check_frame(int idx, logic [7:0] w);
        int c;
        c = cpb(idx);
        for (int k = 0; k < 10 * c; k++) begin
            chk($sformatf("frame_line_k%0d", k), int'(line[idx]), int'(exp_bit(w, k / c)));
            chk($sformatf("frame_done_k%0d", k), int'(dn[idx]), (k == 10 * c - 1) ? 1 : 0);
            chk("frame_busy", int'(bsy[idx]), 1);
            chk("frame_ready", int'(rdy[idx]), 0);
            @(negedge clk);
        end
    endtask

    // Offer one word, then recover it from the line by mid-bit sampling.
    task automatic send_rx(int idx, logic [7:0] w);
        int c, n;
        logic [7:0] got;
        logic st, sp;
        c = cpb(idx);
        din[idx] = w;
        vld[idx] = 1'b1;
        n = 0;
        @(negedge clk);
        while (line[idx] !== 1'b0 && n < 30 * c) begin
            @(negedge clk);
            n++;
        end
        vld[idx] = 1'b0;
        if (line[idx] !== 1'b0) begin
            chk("rx_start_timeout", int'(line[idx]), 0);
            return;
        end
        repeat (c / 2) @(negedge clk);
        st = line[idx];
        for (int b = 0; b < 8; b++) begin
            repeat (c) @(negedge clk);
            got[b] = line[idx];
        end
        repeat (c) @(negedge clk);
        sp = line[idx];
        chk($sformatf("rx_data_%0d", idx), int'(got), int'(w));
        chk($sformatf("rx_framing_%0d", idx), int'({st, sp}), 1);
        n = 0;
        while (rdy[idx] !== 1'b1 && n < 2 * c + 4) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ready_return", int'(rdy[idx]), 1);
    endtask

    initial begin
        int rises, dones, rise_k, lows;
        logic prev_busy;
        logic [9:0] f1, f2;

        // Reset held with Valid high: line stays idle, nothing starts.
        rst    = 3'b111;
        vld    = 3'b001;
        din[0] = 8'h55;
        din[1] = 8'h00;
        din[2] = 8'h00;
        repeat (5) begin
            @(negedge clk);
            chk("rst_line", int'(line), 7);
            chk("rst_ready", int'(rdy), 7);
            chk("rst_busy", int'(bsy), 0);
            chk("rst_done", int'(dn), 0);
        end
        rst = 3'b000;
        vld = 3'b000;
        @(negedge clk);
        chk("post_rst_line", int'(line), 7);
        chk("post_rst_busy", int'(bsy), 0);

        // Single 0xA5 frame at 4 clocks per bit.
        din[0] = 8'hA5;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        check_frame(0, 8'hA5);
        chk("a5_idle_line", int'(line[0]), 1);
        chk("a5_idle_ready", int'(rdy[0]), 1);
        chk("a5_idle_busy", int'(bsy[0]), 0);

        // Back-to-back 0x00 then 0xFF with Valid held.
        din[0] = 8'h00;
        vld[0] = 1'b1;
        @(negedge clk);
        din[0] = 8'hFF;
        check_frame(0, 8'h00);
        chk("b2b_gap_ready", int'(rdy[0]), 1);
        chk("b2b_gap_line", int'(line[0]), 1);
        chk("b2b_gap_busy", int'(bsy[0]), 0);
        @(negedge clk);
        vld[0] = 1'b0;
        check_frame(0, 8'hFF);
        chk("b2b_end_ready", int'(rdy[0]), 1);

        // Valid held 100 cycles mid-frame at 16 clocks per bit, data churning first.
        din[2] = 8'h81;
        vld[2] = 1'b1;
        @(negedge clk);
        vld[2] = 1'b0;
        rises = 0; dones = 0; rise_k = -1; prev_busy = 1'b1;
        f1 = '0; f2 = '0;
        for (int k = 0; k < 400; k++) begin
            if (k >= 1 && k < 100) din[2] = 8'($urandom);
            if (k == 100) begin din[2] = 8'h3C; vld[2] = 1'b1; end
            if (k == 200) vld[2] = 1'b0;
            if (k < 160 && k % 16 == 8) f1[k / 16] = line[2];
            if (k >= 161 && k < 321 && (k - 161) % 16 == 8) f2[(k - 161) / 16] = line[2];
            if (bsy[2] && !prev_busy) begin rises++; rise_k = k; end
            prev_busy = bsy[2];
            if (dn[2]) dones++;
            @(negedge clk);
        end
        chk("vb_frame1", int'(f1), int'({1'b1, 8'h81, 1'b0}));
        chk("vb_frame2", int'(f2), int'({1'b1, 8'h3C, 1'b0}));
        chk("vb_new_frames", rises, 1);
        chk("vb_start_cycle", rise_k, 161);
        chk("vb_done_count", dones, 2);
        chk("vb_final_ready", int'(rdy[2]), 1);

        // Reset during data bit 3 of a 0x5A frame (frame bit 4, cycles 16..19).
        din[0] = 8'h5A;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("mf_start", int'(line[0]), 0);
        repeat (17) @(negedge clk);
        chk("mf_bit3", int'(line[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("mf_line", int'(line[0]), 1);
        chk("mf_ready", int'(rdy[0]), 1);
        chk("mf_busy", int'(bsy[0]), 0);
        chk("mf_done", int'(dn[0]), 0);
        dones = 0; lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn[0]) dones++;
            if (!line[0]) lows++;
        end
        chk("mf_no_done", dones, 0);
        chk("mf_line_quiet", lows, 0);
        send_rx(0, 8'hC3);

        // Random sweeps at 4 and 1 clocks per bit.
        for (int i = 0; i < 200; i++) send_rx(0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 200; i++) send_rx(1, 8'($urandom_range(0, 255)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
